pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised successor to the fixed-field ID/EX stage register: one generic pipeline stage carrying a packed payload of any width between two pipeline stages.
- Adds a valid/ready handshake with a 2-entry skid buffer, so in_ready never depends combinationally on out_ready.
- Keeps hold (stall) and flush (bubble) control; flush zeroes selected payload fields.
- Adds saturating transfer and backpressure counters for performance monitoring.

Parameters:
W, 160, payload width in bits (packed stage fields, e.g. PC, imm, rd, control).
CLR_MASK, {W{1'b1}}, payload bits forced to 0 on flush or drain-to-empty; 0-bits hold their value.
CNT_W, 16, width of the performance counters.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream payload valid
in_ready  out  1  stage can accept a payload
in_data  in  W  upstream payload
out_valid  out  1  payload available downstream
out_ready  in  1  downstream accepts payload
out_data  out  W  payload to downstream (main entry)
hold  in  1  freeze stage: no transfers, state and data unchanged
flush  in  1  discard all held entries (bubble insertion)
occupancy  out  2  entries held: 0, 1 or 2
xfer_cnt  out  CNT_W  output transfers, saturating
bp_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating
cnt_clr  in  1  synchronous clear of both counters

Behaviour:
- Storage: main register (drives out_data) and skid register. States EMPTY, ONE, TWO; occupancy = 0/1/2 respectively.
- Reset (rst_n=0, async):
  - state EMPTY; main and skid all-zero; counters 0.
  - Outputs: out_valid=0, out_data=0, occupancy=0, xfer_cnt=bp_cnt=0.
  - in_ready=1 whenever hold=0.
- Combinational outputs:
  - in_ready = (state != TWO) & ~hold.
  - out_valid = (state != EMPTY) & ~hold.
  - in_ready has no path from out_ready.
- Fire rules: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Latency: 1 cycle from in_fire to out_valid when EMPTY. Throughput: 1 payload per cycle sustained.
- Transitions (flush=0):
  - EMPTY: in_fire -> ONE, main <= in_data.
  - ONE, in_fire only -> TWO, skid <= in_data.
  - ONE, out_fire only -> EMPTY, main <= main & ~CLR_MASK.
  - ONE, both fire -> ONE, main <= in_data.
  - TWO: out_fire -> ONE, main <= skid. No input accepted in TWO.
- Ordering: strict FIFO order; no payload is dropped or duplicated.
- hold=1 (flush=0):
  - No fire of either kind; all state and data frozen.
  - Counters frozen, including bp_cnt.
- flush=1:
  - Highest priority, wins over hold and over any in_fire/out_fire that cycle. The handshake outputs still show their combinational values, but that cycle's transfers are discarded.
  - Next state EMPTY; main <= main & ~CLR_MASK; skid <= 0.
  - xfer_cnt does not count the discarded transfer.
- Counters:
  - xfer_cnt += 1 on out_fire when flush=0; bp_cnt += 1 when out_valid & ~out_ready & ~flush.
  - Both saturate at all-ones, no wrap.
  - cnt_clr zeroes both next cycle and has priority over increment.
  - Counters ignore flush for clearing.
- Reset asserted mid-operation: contents lost, EMPTY immediately (async), no output glitch beyond the reset values.
- X-safety: in_data is sampled only on in_fire; registers never load X when in_valid=0.

Decomposition:
- Package pipe_pkg: state enum (EMPTY/ONE/TWO, 2-bit encoding), occupancy encodings, and default CLR_MASK constants for the standard stage payload layouts (ID/EX, EX/MEM, MEM/WB) with their field offsets.
- Sub-module: sat_counter (CNT_W, inc, clr, count), instantiated twice for xfer_cnt and bp_cnt.

Test Plan:
- Reset then stream 0x1..0x8 with in_valid=1 and out_ready=1 -> out_data 0x1..0x8 on consecutive cycles, 1-cycle latency; occupancy=1 throughout; xfer_cnt=8.
- Fill with out_ready=0: send 0xA, 0xB, 0xC -> in_ready drops after 0xB, occupancy=2, bp_cnt increments per cycle. Raise out_ready -> outputs 0xA, 0xB, then 0xC; none lost.
- Occupancy=2, assert flush with hold=1 and in_valid=1 -> next cycle occupancy=0, out_valid=0, CLR_MASK bits of out_data=0, unmasked bits unchanged; xfer_cnt unchanged.
- Occupancy=1 holding 0x55, hold=1 for 3 cycles with out_ready=1 -> out_valid=0, in_ready=0, data 0x55 retained, counters frozen; on release, 0x55 is delivered once.
- Force bp_cnt to all-ones with CNT_W=4 for 20 backpressure cycles -> bp_cnt sticks at 0xF. Assert cnt_clr with a simultaneous increment -> 0.
- Deassert rst_n asynchronously mid-stream at occupancy=2 -> outputs are reset values immediately, before the next clk edge; after release, the first new input appears 1 cycle later.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// pipe_pkg: shared stage-register types, occupancy codes and standard payload clear masks
package pipe_pkg;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;
  localparam int MASK_W = 160;
  function automatic logic [MASK_W-1:0] field_mask(input int lo, input int w);
    logic [MASK_W-1:0] m;
    m = '0;
    for (int i = 0; i < MASK_W; i++) m[i] = (i >= lo) && (i < lo + w);
    return m;
  endfunction
  localparam int IDEX_W       = 160;
  localparam int IDEX_PC_LO   = 0;
  localparam int IDEX_IMM_LO  = 32;
  localparam int IDEX_RS1_LO  = 64;
  localparam int IDEX_RS2_LO  = 96;
  localparam int IDEX_RD_LO   = 128;
  localparam int IDEX_CTRL_LO = 133;
  localparam int IDEX_CTRL_W  = 27;
  localparam logic [IDEX_W-1:0] IDEX_CLR_MASK =
    field_mask(IDEX_RD_LO, 5) | field_mask(IDEX_CTRL_LO, IDEX_CTRL_W);
  localparam int EXMEM_W        = 112;
  localparam int EXMEM_PC_LO    = 0;
  localparam int EXMEM_ALU_LO   = 32;
  localparam int EXMEM_STORE_LO = 64;
  localparam int EXMEM_RD_LO    = 96;
  localparam int EXMEM_CTRL_LO  = 101;
  localparam int EXMEM_CTRL_W   = 11;
  localparam logic [MASK_W-1:0] EXMEM_CLR_FULL =
    field_mask(EXMEM_RD_LO, 5) | field_mask(EXMEM_CTRL_LO, EXMEM_CTRL_W);
  localparam logic [EXMEM_W-1:0] EXMEM_CLR_MASK = EXMEM_CLR_FULL[EXMEM_W-1:0];
  localparam int MEMWB_W       = 72;
  localparam int MEMWB_RES_LO  = 0;
  localparam int MEMWB_PC_LO   = 32;
  localparam int MEMWB_RD_LO   = 64;
  localparam int MEMWB_CTRL_LO = 69;
  localparam int MEMWB_CTRL_W  = 3;
  localparam logic [MASK_W-1:0] MEMWB_CLR_FULL =
    field_mask(MEMWB_RD_LO, 5) | field_mask(MEMWB_CTRL_LO, MEMWB_CTRL_W);
  localparam logic [MEMWB_W-1:0] MEMWB_CLR_MASK = MEMWB_CLR_FULL[MEMWB_W-1:0];
endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear taking priority over increment
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else if (clr) count <= '0;
    else if (inc && !(&count)) count <= count + 1'b1;
  end
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic valid/ready pipeline stage with 2-entry skid buffer, hold, flush and perf counters
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int             W        = 160,
  parameter logic [W-1:0]   CLR_MASK = {W{1'b1}},
  parameter int             CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  input  logic             hold,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] xfer_cnt,
  output logic [CNT_W-1:0] bp_cnt,
  input  logic             cnt_clr
);
  state_t state;
  logic [W-1:0] main_q, skid_q;
  logic in_fire, out_fire;
  assign in_ready  = (state != TWO) && !hold;
  assign out_valid = (state != EMPTY) && !hold;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign out_data  = main_q;
  always_comb occupancy = (state == TWO) ? OCC_TWO : (state == ONE) ? OCC_ONE : OCC_EMPTY;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state  <= EMPTY;
      main_q <= main_q & ~CLR_MASK;
      skid_q <= '0;
    end else if (state == EMPTY) begin
      if (in_fire) begin
        state  <= ONE;
        main_q <= in_data;
      end
    end else if (state == ONE) begin
      if (in_fire && out_fire) main_q <= in_data;
      else if (in_fire) begin
        state  <= TWO;
        skid_q <= in_data;
      end else if (out_fire) begin
        state  <= EMPTY;
        main_q <= main_q & ~CLR_MASK;
      end
    end else if (out_fire) begin
      state  <= ONE;
      main_q <= skid_q;
    end
  end
  sat_counter #(.CNT_W(CNT_W)) u_xfer (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (out_fire && !flush),
    .clr   (cnt_clr),
    .count (xfer_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_bp (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (out_valid && !out_ready && !flush),
    .clr   (cnt_clr),
    .count (bp_cnt)
  );
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: queue-model checked random and directed stimulus for pipe_stage_reg
module tb_pipe_stage_reg;
  localparam int W = 16;
  localparam logic [W-1:0] M = 16'h0F0F;
  localparam int CNT_W = 4;
  localparam int CMAX = (1 << CNT_W) - 1;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_ready, out_valid, out_ready = 0, hold = 0, flush = 0, cnt_clr = 0;
  logic [W-1:0] in_data = '0, out_data;
  logic [1:0] occupancy;
  logic [CNT_W-1:0] xfer_cnt, bp_cnt;
  int checks = 0, errors = 0;
  logic [W-1:0] q[$];
  logic [W-1:0] empty_data = '0;
  int m_x = 0, m_b = 0;
  pipe_stage_reg #(.W(W), .CLR_MASK(M), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .hold(hold),
    .flush(flush), .occupancy(occupancy), .xfer_cnt(xfer_cnt), .bp_cnt(bp_cnt), .cnt_clr(cnt_clr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  initial forever begin
    bit ir, ov, inf, outf;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      q.delete();
      empty_data = '0;
      m_x = 0;
      m_b = 0;
    end else begin
      ir = q.size() < 2 && !hold;
      ov = q.size() > 0 && !hold;
      inf = in_valid && ir;
      outf = ov && out_ready;
      if (cnt_clr) begin
        m_x = 0;
        m_b = 0;
      end else begin
        if (outf && !flush && m_x < CMAX) m_x++;
        if (ov && !out_ready && !flush && m_b < CMAX) m_b++;
      end
      if (flush) begin
        empty_data = (q.size() > 0 ? q[0] : empty_data) & ~M;
        q.delete();
      end else begin
        if (outf) begin
          if (q.size() == 1 && !inf) empty_data = q[0] & ~M;
          void'(q.pop_front());
        end
        if (inf) q.push_back(in_data);
      end
    end
  end
  initial forever begin
    @(negedge clk);
    chk("in_ready", in_ready, q.size() < 2 && !hold);
    chk("out_valid", out_valid, q.size() > 0 && !hold);
    chk("occupancy", occupancy, q.size());
    chk("out_data", out_data, q.size() > 0 ? q[0] : empty_data);
    chk("xfer_cnt", xfer_cnt, m_x);
    chk("bp_cnt", bp_cnt, m_b);
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    in_valid = 0; out_ready = 0; hold = 0; flush = 0; cnt_clr = 0;
  endtask
  initial begin
    #2;
    chk("rst out_valid", out_valid, 0);
    chk("rst in_ready", in_ready, 1);
    chk("rst occ", occupancy, 0);
    chk("rst out_data", out_data, 0);
    chk("rst xfer", xfer_cnt, 0);
    chk("rst bp", bp_cnt, 0);
    cyc();
    rst_n = 1;
    for (int i = 1; i <= 9; i++) begin
      cyc();
      if (i > 1) begin
        #1;
        chk("stream data", out_data, i - 1);
        chk("stream occ", occupancy, 1);
      end
      in_valid = i <= 8;
      in_data = W'(i);
      out_ready = 1;
    end
    cyc();
    #1;
    chk("stream xfer", xfer_cnt, 8);
    chk("stream drained", occupancy, 0);
    idle();
    cnt_clr = 1;
    cyc();
    cnt_clr = 0;
    in_valid = 1; in_data = 16'h000A;
    cyc();
    in_data = 16'h000B;
    cyc();
    in_data = 16'h000C;
    #1;
    chk("fill in_ready", in_ready, 0);
    chk("fill occ", occupancy, 2);
    cyc();
    #1;
    chk("fill bp", bp_cnt, 2);
    cyc();
    out_ready = 1;
    #1;
    chk("drain A", out_data, 16'h000A);
    cyc();
    #1;
    chk("drain B", out_data, 16'h000B);
    cyc();
    in_valid = 0;
    #1;
    chk("drain C", out_data, 16'h000C);
    cyc();
    idle();
    in_valid = 1; in_data = 16'h1234;
    cyc();
    in_data = 16'h5678;
    cyc();
    in_data = 16'h9999; hold = 1; flush = 1;
    cyc();
    idle();
    #1;
    chk("flush occ", occupancy, 0);
    chk("flush out_valid", out_valid, 0);
    chk("flush data", out_data, 16'h1030);
    in_valid = 1; in_data = 16'h0055;
    cyc();
    in_valid = 0; hold = 1; out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold out_valid", out_valid, 0);
      chk("hold in_ready", in_ready, 0);
      chk("hold data", out_data, 16'h0055);
      cyc();
    end
    hold = 0;
    #1;
    chk("release valid", out_valid, 1);
    cyc();
    idle();
    in_valid = 1; in_data = 16'h00F1;
    cyc();
    in_valid = 0;
    repeat (20) cyc();
    chk("bp sat", bp_cnt, 4'hF);
    cnt_clr = 1;
    cyc();
    cnt_clr = 0;
    #1;
    chk("bp clr", bp_cnt, 0);
    idle();
    in_valid = 1; in_data = 16'h0101;
    cyc();
    in_data = 16'h0202;
    cyc();
    in_valid = 0;
    #1;
    rst_n = 0;
    #1;
    chk("async out_valid", out_valid, 0);
    chk("async occ", occupancy, 0);
    chk("async data", out_data, 0);
    chk("async in_ready", in_ready, 1);
    cyc();
    rst_n = 1;
    in_valid = 1; in_data = 16'h0077;
    cyc();
    in_valid = 0;
    #1;
    chk("post rst valid", out_valid, 1);
    chk("post rst data", out_data, 16'h0077);
    for (int i = 0; i < 3000; i++) begin
      cyc();
      in_valid = $urandom_range(0, 3) != 0;
      in_data = W'($urandom);
      out_ready = $urandom_range(0, 2) != 0;
      hold = $urandom_range(0, 9) == 0;
      flush = $urandom_range(0, 24) == 0;
      cnt_clr = $urandom_range(0, 49) == 0;
    end
    cyc();
    idle();
    cyc();
    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
